// File: rtl/if_id_skid.sv
// IF/ID pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// registered fetch-side ready, flush, and MIPS field decode of the held word.
module if_id_skid #(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned PC_W        = 32,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         OpCode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         Shamt,
  output logic [5:0]         Funct,
  output logic [1:0]         occupancy
);

  // bit0 = main valid, bit1 = skid valid
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_e;

  state_e             r_state;
  state_e             w_next;
  logic               r_in_ready;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic w_accept;
  logic w_deliver;
  logic w_load_main_in;
  logic w_load_skid_in;
  logic w_promote;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_state[0] & out_ready;

  // Next state and payload load enables
  always_comb begin
    w_next         = r_state;
    w_load_main_in = 1'b0;
    w_load_skid_in = 1'b0;
    w_promote      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_load_main_in = 1'b1;
          w_next         = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_deliver) begin
          w_load_main_in = 1'b1;
        end else if (w_deliver) begin
          w_next = S_EMPTY;
        end else if (w_accept) begin
          w_load_skid_in = 1'b1;
          w_next         = S_FULL;
        end
      end
      S_FULL: begin
        if (w_deliver) begin
          w_promote = 1'b1;
          w_next    = S_ONE;
        end
      end
      default: w_next = S_EMPTY;
    endcase
    if (flush) begin
      w_next         = S_EMPTY;
      w_load_main_in = 1'b0;
      w_load_skid_in = 1'b0;
      w_promote      = 1'b0;
    end
  end

  // State and registered ready; ready stays low for the first cycle out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_FULL);
    end
  end

  // Payload registers load only on accept or promotion, cleared by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (flush) begin
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_instr <= in_instr;
        r_main_pc    <= in_pc;
      end else if (w_promote) begin
        r_main_instr <= r_skid_instr;
        r_main_pc    <= r_skid_pc;
      end
      if (w_load_skid_in) begin
        r_skid_instr <= in_instr;
        r_skid_pc    <= in_pc;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_state[0];
  assign occupancy = (r_state == S_FULL) ? 2'd2 :
                     (r_state == S_ONE)  ? 2'd1 : 2'd0;

  if (ZERO_BUBBLE) begin : g_zero_bubble
    assign out_instr = out_valid ? r_main_instr : '0;
    assign out_pc    = out_valid ? r_main_pc    : '0;
  end else begin : g_hold_last
    assign out_instr = r_main_instr;
    assign out_pc    = r_main_pc;
  end

  assign OpCode = out_instr[31:26];
  assign rs     = out_instr[25:21];
  assign rt     = out_instr[20:16];
  assign rd     = out_instr[15:11];
  assign Shamt  = out_instr[10:6];
  assign Funct  = out_instr[5:0];

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table, async-reset sequence, and
// randomized traffic against a queue-based reference model.
module tb_if_id_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [5:0]  OpCode, Funct;
  logic [4:0]  rs, rt, rd, Shamt;
  logic [1:0]  occupancy;

  logic        nb_in_ready, nb_out_valid;
  logic [31:0] nb_out_instr, nb_out_pc;
  logic [5:0]  nb_OpCode, nb_Funct;
  logic [4:0]  nb_rs, nb_rt, nb_rd, nb_Shamt;
  logic [1:0]  nb_occupancy;

  if_id_skid #(.INSTR_W(32), .PC_W(32), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .OpCode(OpCode), .rs(rs), .rt(rt), .rd(rd),
    .Shamt(Shamt), .Funct(Funct), .occupancy(occupancy)
  );

  if_id_skid #(.INSTR_W(32), .PC_W(32), .ZERO_BUBBLE(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nb_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(nb_out_valid), .out_ready(out_ready),
    .out_instr(nb_out_instr), .out_pc(nb_out_pc), .OpCode(nb_OpCode), .rs(nb_rs), .rt(nb_rt),
    .rd(nb_rd), .Shamt(nb_Shamt), .Funct(nb_Funct), .occupancy(nb_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO of held entries, ready flag, and last main contents
  typedef struct packed { logic [31:0] ins; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  logic        m_rdy = 1'b0;
  logic [31:0] m_last_ins = '0;
  logic [31:0] m_last_pc  = '0;

  task automatic model_reset();
    q.delete();
    m_rdy      = 1'b0;
    m_last_ins = '0;
    m_last_pc  = '0;
  endtask

  task automatic model_edge();
    logic acc;
    ent_t e;
    if (!reset) begin
      model_reset();
    end else if (flush) begin
      q.delete();
      m_rdy      = 1'b1;
      m_last_ins = '0;
      m_last_pc  = '0;
    end else begin
      acc = in_valid & m_rdy;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        e.ins = in_instr;
        e.pc  = in_pc;
        q.push_back(e);
      end
      m_rdy = (q.size() < 2);
      if (q.size() > 0) begin
        m_last_ins = q[0].ins;
        m_last_pc  = q[0].pc;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_outputs(input logic ev, input logic [31:0] eins, input logic [31:0] epc,
                               input logic [1:0] eocc, input logic erdy);
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_instr", 64'(out_instr), 64'(eins));
    chk("out_pc", 64'(out_pc), 64'(epc));
    chk("occupancy", 64'(occupancy), 64'(eocc));
    chk("in_ready", 64'(in_ready), 64'(erdy));
    chk("fields", 64'({OpCode, rs, rt, rd, Shamt, Funct}), 64'(eins));
    chk("nb_out_valid", 64'(nb_out_valid), 64'(ev));
    chk("nb_in_ready", 64'(nb_in_ready), 64'(erdy));
    chk("nb_occupancy", 64'(nb_occupancy), 64'(eocc));
    chk("nb_out_instr", 64'(nb_out_instr), 64'(m_last_ins));
    chk("nb_out_pc", 64'(nb_out_pc), 64'(m_last_pc));
    chk("nb_fields", 64'({nb_OpCode, nb_rs, nb_rt, nb_rd, nb_Shamt, nb_Funct}), 64'(m_last_ins));
  endtask

  task automatic check_model();
    logic [31:0] eins, epc;
    eins = (q.size() > 0) ? q[0].ins : 32'h0;
    epc  = (q.size() > 0) ? q[0].pc  : 32'h0;
    check_outputs(q.size() > 0, eins, epc, 2'(q.size()), m_rdy);
  endtask

  // Drive inputs just after an edge, advance one edge, sample 1 time unit later
  task automatic step(input logic r, input logic f, input logic v, input logic o,
                      input logic [31:0] ins, input logic [31:0] pc);
    reset     = r;
    flush     = f;
    in_valid  = v;
    out_ready = o;
    in_instr  = ins;
    in_pc     = pc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic r, f, v, o;
    logic [31:0] ins, pc;
    logic e_v;
    logic [31:0] e_ins, e_pc;
    logic [1:0] e_occ;
    logic e_rdy;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic v, logic o, logic [31:0] ins, logic [31:0] pc,
                              logic ev, logic [31:0] eins, logic [31:0] epc, logic [1:0] eocc,
                              logic erdy);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.o = o; t.ins = ins; t.pc = pc;
    t.e_v = ev; t.e_ins = eins; t.e_pc = epc; t.e_occ = eocc; t.e_rdy = erdy;
    return t;
  endfunction

  localparam logic [31:0] IA = 32'h8C220004, PA = 32'h0;
  localparam logic [31:0] IB = 32'h00430820, PB = 32'h4;
  localparam logic [31:0] IC = 32'h12345678, PC = 32'h8;
  localparam logic [31:0] ID = 32'hDEADBEEF, PD = 32'hC;

  vec_t tbl[$];

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    // reset / stream
    repeat (3) tbl.push_back(mk(0,0,0,0, 0,0,  0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1, 0,0,   0,0,0,0,1));
    tbl.push_back(mk(1,0,1,1, IA,PA, 1,IA,PA,1,1));
    tbl.push_back(mk(1,0,1,1, IB,PB, 1,IB,PB,1,1));
    tbl.push_back(mk(1,0,0,1, 0,0,   0,0,0,0,1));
    // backpressure into the skid, then drain
    tbl.push_back(mk(1,0,1,0, IA,PA, 1,IA,PA,1,1));
    tbl.push_back(mk(1,0,1,0, IB,PB, 1,IA,PA,2,0));
    tbl.push_back(mk(1,0,1,0, IC,PC, 1,IA,PA,2,0));
    tbl.push_back(mk(1,0,1,1, IC,PC, 1,IB,PB,1,1));
    tbl.push_back(mk(1,0,1,1, IC,PC, 1,IC,PC,1,1));
    tbl.push_back(mk(1,0,0,1, 0,0,   0,0,0,0,1));
    // flush while full with an incoming beat
    tbl.push_back(mk(1,0,1,0, IA,PA, 1,IA,PA,1,1));
    tbl.push_back(mk(1,0,1,0, IB,PB, 1,IA,PA,2,0));
    tbl.push_back(mk(1,1,1,0, IC,PC, 0,0,0,0,1));
    tbl.push_back(mk(1,0,0,1, 0,0,   0,0,0,0,1));
    // flush in ONE with out_ready=1: held entry consumed, incoming beat dropped
    tbl.push_back(mk(1,0,1,0, ID,PD, 1,ID,PD,1,1));
    tbl.push_back(mk(1,1,1,1, IA,PA, 0,0,0,0,1));
    tbl.push_back(mk(1,0,0,1, 0,0,   0,0,0,0,1));

    #1;
    check_outputs(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].o, tbl[i].ins, tbl[i].pc);
      check_outputs(tbl[i].e_v, tbl[i].e_ins, tbl[i].e_pc, tbl[i].e_occ, tbl[i].e_rdy);
      if (tbl[i].e_v && tbl[i].e_ins == IA) begin
        chk("OpCode", 64'(OpCode), 64'h23);
        chk("rs", 64'(rs), 64'h1);
        chk("rt", 64'(rt), 64'h2);
      end
    end

    // async reset mid-cycle while FULL
    step(1,0,1,0, IA,PA); check_model();
    step(1,0,1,0, IB,PB); check_model();
    chk("full_before_reset", 64'(occupancy), 64'd2);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_model();
    step(0,0,0,0, 0,0); check_model();
    step(1,0,0,1, 0,0); check_model();
    step(1,0,1,1, ID,PD); check_model();
    chk("post_reset_beat", 64'(out_instr), 64'(ID));
    step(1,0,0,1, 0,0); check_model();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 97) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
           ($urandom % 3) != 0, $urandom, $urandom);
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
